bram_port_arbiter: RTL and testbench

- Shares one single-port BRAM (data, weight or op store) between two requesters.
  - Requester A is the host/UART comms path.
  - Requester B is the inference compute engine.
- Grants ownership with round-robin arbitration. An owner may lock the port for a burst, for example a 16-piece row transfer.
- Issues registered BRAM commands and tracks BRAM read latency so that each read return is steered to the requester that issued it.
- Instantiated once per BRAM, between the comms block, the compute engine and the BRAM macro.

---
 rtl/bram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin owner arbiter sharing one single-port BRAM between the host
// comms path (A) and the compute engine (B), with burst lock and read steering.
//
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   a_req_in/a_lock_in/a_we_in     requester A access request, lock, write
//   a_addr_in/a_wdata_in           requester A address and write data
//   a_grant_out                    A owns the port (access = req && grant)
//   a_rvalid_out/a_rdata_out       read return to A
//   b_*                            same set for requester B
//   bram_en_out/bram_we_out        registered BRAM enable / write enable
//   bram_addr_out/bram_wdata_out   registered BRAM address / write data
//   bram_rdata_in                  BRAM read data
//   owner_out                      00 idle, 01 A, 10 B
//
// Optional: define ARB_HOST_PRIORITY_EN to give A fixed priority over B
// instead of round-robin.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  a_req_in,
    input  logic                  a_lock_in,
    input  logic                  a_we_in,
    input  logic [ADDR_WIDTH-1:0] a_addr_in,
    input  logic [DATA_WIDTH-1:0] a_wdata_in,
    output logic                  a_grant_out,
    output logic                  a_rvalid_out,
    output logic [DATA_WIDTH-1:0] a_rdata_out,
    input  logic                  b_req_in,
    input  logic                  b_lock_in,
    input  logic                  b_we_in,
    input  logic [ADDR_WIDTH-1:0] b_addr_in,
    input  logic [DATA_WIDTH-1:0] b_wdata_in,
    output logic                  b_grant_out,
    output logic                  b_rvalid_out,
    output logic [DATA_WIDTH-1:0] b_rdata_out,
    output logic                  bram_en_out,
    output logic                  bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_wdata_out,
    input  logic [DATA_WIDTH-1:0] bram_rdata_in,
    output logic [1:0]            owner_out
);

    // State encoding doubles as the owner code and the grant bits.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_OWN_A = 2'b01;
    localparam logic [1:0] ST_OWN_B = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last_b;
    logic       w_next_last_b;

    logic       w_acc_a;
    logic       w_acc_b;
    logic       w_rel_a;
    logic       w_rel_b;
    logic       w_rd_acc;

    logic [READ_LATENCY:0] r_rd_vld;
    logic [READ_LATENCY:0] r_rd_id;

    assign w_acc_a = a_req_in & (r_state == ST_OWN_A);
    assign w_acc_b = b_req_in & (r_state == ST_OWN_B);

    // Owner gives up the port on an unlocked access or when idle and unlocked.
    assign w_rel_a = (w_acc_a & ~a_lock_in) | (~a_req_in & ~a_lock_in);
    assign w_rel_b = (w_acc_b & ~b_lock_in) | (~b_req_in & ~b_lock_in);

    assign w_rd_acc = (w_acc_a & ~a_we_in) | (w_acc_b & ~b_we_in);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_last_b <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_last_b <= w_next_last_b;
        end
    end

    // Next-state logic
    always_comb begin
        w_next        = r_state;
        w_next_last_b = r_last_b;
        unique case (r_state)
            ST_IDLE: begin
                if (a_req_in && b_req_in) begin
`ifdef ARB_HOST_PRIORITY_EN
                    w_next = ST_OWN_A;
`else
                    w_next = r_last_b ? ST_OWN_A : ST_OWN_B;
`endif
                end else if (a_req_in) begin
                    w_next = ST_OWN_A;
                end else if (b_req_in) begin
                    w_next = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (w_rel_a) begin
                    w_next_last_b = 1'b0;
`ifdef ARB_HOST_PRIORITY_EN
                    // A re-requesting goes back through IDLE and wins there.
                    w_next = (b_req_in && !a_req_in) ? ST_OWN_B : ST_IDLE;
`else
                    w_next = b_req_in ? ST_OWN_B : ST_IDLE;
`endif
                end
            end
            ST_OWN_B: begin
                if (w_rel_b) begin
                    w_next_last_b = 1'b1;
                    w_next        = a_req_in ? ST_OWN_A : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        a_grant_out = (r_state == ST_OWN_A);
        b_grant_out = (r_state == ST_OWN_B);
        owner_out   = r_state;
    end

    // Registered BRAM command
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bram_en_out    <= 1'b0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_wdata_out <= '0;
        end else if (w_acc_a) begin
            bram_en_out    <= 1'b1;
            bram_we_out    <= a_we_in;
            bram_addr_out  <= a_addr_in;
            bram_wdata_out <= a_wdata_in;
        end else if (w_acc_b) begin
            bram_en_out    <= 1'b1;
            bram_we_out    <= b_we_in;
            bram_addr_out  <= b_addr_in;
            bram_wdata_out <= b_wdata_in;
        end else begin
            bram_en_out    <= 1'b0;
            bram_we_out    <= 1'b0;
        end
    end

    // Read tracker: stage k is live k+1 cycles after acceptance, so the last
    // stage lines up with data arriving READ_LATENCY cycles after bram_en.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_vld <= '0;
            r_rd_id  <= '0;
        end else begin
            r_rd_vld <= {r_rd_vld[READ_LATENCY-1:0], w_rd_acc};
            r_rd_id  <= {r_rd_id[READ_LATENCY-1:0], w_acc_b};
        end
    end

    assign a_rvalid_out = r_rd_vld[READ_LATENCY] & ~r_rd_id[READ_LATENCY];
    assign b_rvalid_out = r_rd_vld[READ_LATENCY] &  r_rd_id[READ_LATENCY];
    assign a_rdata_out  = bram_rdata_in;
    assign b_rdata_out  = bram_rdata_in;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a two-cycle BRAM model.
module tb_bram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_grant, a_rvalid, b_grant, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic [1:0]    owner;

    logic [DW-1:0] p1 = '0, p2 = '0;

    int n_chk = 0;
    int n_err = 0;

    bram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .a_req_in(a_req), .a_lock_in(a_lock), .a_we_in(a_we),
        .a_addr_in(a_addr), .a_wdata_in(a_wdata),
        .a_grant_out(a_grant), .a_rvalid_out(a_rvalid), .a_rdata_out(a_rdata),
        .b_req_in(b_req), .b_lock_in(b_lock), .b_we_in(b_we),
        .b_addr_in(b_addr), .b_wdata_in(b_wdata),
        .b_grant_out(b_grant), .b_rvalid_out(b_rvalid), .b_rdata_out(b_rdata),
        .bram_en_out(bram_en), .bram_we_out(bram_we),
        .bram_addr_out(bram_addr), .bram_wdata_out(bram_wdata),
        .bram_rdata_in(bram_rdata), .owner_out(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] ad);
        return {32'hDEADBEEF, 18'h0, ad};
    endfunction

    // BRAM model: data for a read enabled in cycle c is valid in cycle c+2.
    always @(posedge clk) begin
        if (bram_en && !bram_we) p1 <= mdata(bram_addr);
        p2 <= p1;
    end
    assign bram_rdata = p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset state
        step(); step(); step();
        chk("rst_agrant", a_grant, 0);
        chk("rst_bgrant", b_grant, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_wdata", bram_wdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rv", {a_rvalid, b_rvalid}, 0);
        rst = 1'b0;
        step();

        // ---- single A read at 0x0005
        a_req = 1; a_lock = 0; a_we = 0; a_addr = 14'h0005;
        chk("t1_nogrant_same_cycle", a_grant, 0);
        step();
        chk("t1_grant", a_grant, 1);
        chk("t1_owner_a", owner, 2'b01);
        step();
        a_req = 0;
        chk("t1_en", bram_en, 1);
        chk("t1_we", bram_we, 0);
        chk("t1_addr", bram_addr, 14'h0005);
        chk("t1_grant_drop", a_grant, 0);
        chk("t1_owner_idle", owner, 0);
        step();
        chk("t1_en_off", bram_en, 0);
        chk("t1_rv_early", a_rvalid, 0);
        step();
        chk("t1_arv", a_rvalid, 1);
        chk("t1_rdata", a_rdata, 64'hDEADBEEF00000005);
        chk("t1_brv", b_rvalid, 0);
        step();
        chk("t1_arv_once", a_rvalid, 0);

        // ---- tie out of reset, handoff, second tie
        rst = 1; step(); step();
        rst = 0;
        a_req = 1; a_addr = 14'h0010; a_we = 0; a_lock = 0;
        b_req = 1; b_addr = 14'h0020; b_we = 0; b_lock = 0;
        step();
        chk("t2_tie_a", {b_grant, a_grant}, 2'b01);
        step();
        a_req = 0;
        chk("t2_handoff_b", {b_grant, a_grant}, 2'b10);
        chk("t2_owner_b", owner, 2'b10);
        step();
        a_req = 1;
        chk("t2_idle", owner, 0);
        step();
        a_req = 0; b_req = 0;
        chk("t2_tie2_a", {b_grant, a_grant}, 2'b01);
        chk("t2_arv", a_rvalid, 1);
        chk("t2_ardata", a_rdata, 64'hDEADBEEF00000010);
        step();
        chk("t2_brv", {b_rvalid, a_rvalid}, 2'b10);
        chk("t2_brdata", b_rdata, 64'hDEADBEEF00000020);
        chk("t2_back_idle", owner, 0);

        // ---- A locked 16-word write burst while B waits
        a_req = 1; a_lock = 1; a_we = 1; a_addr = 14'h0100;
        a_wdata = 64'h1000;
        step();
        b_req = 1; b_we = 0; b_lock = 0; b_addr = 14'h0030;
        for (int i = 0; i < 16; i++) begin
            a_addr  = 14'(14'h0100 + i);
            a_wdata = 64'(64'h1000 + i);
            a_lock  = (i < 15);
            chk("t3_agrant", a_grant, 1);
            chk("t3_bgrant", b_grant, 0);
            if (i > 0) begin
                chk("t3_en", {bram_en, bram_we}, 2'b11);
                chk("t3_addr", bram_addr, 14'(14'h0100 + i - 1));
            end
            step();
        end
        chk("t3_last_en", {bram_en, bram_we}, 2'b11);
        chk("t3_last_addr", bram_addr, 14'h010F);
        chk("t3_last_wdata", bram_wdata, 64'h100F);
        chk("t3_b_granted", {b_grant, a_grant}, 2'b10);

        // ---- B three back-to-back reads, A requests in the middle
        a_req = 0; a_lock = 0;
        b_lock = 1; b_addr = 14'h0040;
        step();
        b_addr = 14'h0041;
        a_req = 1; a_we = 1; a_addr = 14'h0050; a_wdata = 64'h55;
        chk("t4_bgrant1", {b_grant, a_grant}, 2'b10);
        step();
        b_addr = 14'h0042; b_lock = 0;
        chk("t4_bgrant2", {b_grant, a_grant}, 2'b10);
        step();
        b_req = 0;
        chk("t4_agrant", {b_grant, a_grant}, 2'b01);
        chk("t4_rv0", {b_rvalid, a_rvalid}, 2'b10);
        chk("t4_d0", b_rdata, 64'hDEADBEEF00000040);
        step();
        a_req = 0; a_we = 0;
        chk("t4_rv1", {b_rvalid, a_rvalid}, 2'b10);
        chk("t4_d1", b_rdata, 64'hDEADBEEF00000041);
        chk("t4_awrite", {bram_en, bram_we}, 2'b11);
        step();
        chk("t4_rv2", {b_rvalid, a_rvalid}, 2'b10);
        chk("t4_d2", b_rdata, 64'hDEADBEEF00000042);
        step();
        chk("t4_rv_end", {b_rvalid, a_rvalid}, 2'b00);

        // ---- reset with two reads in flight
        a_req = 1; a_lock = 1; a_we = 0; a_addr = 14'h0060;
        step();
        chk("t5_grant", a_grant, 1);
        step();
        a_addr = 14'h0061; a_lock = 0;
        step();
        a_req = 0; rst = 1;
        step();
        rst = 0;
        chk("t5_rv", {b_rvalid, a_rvalid}, 2'b00);
        chk("t5_grant0", {b_grant, a_grant}, 2'b00);
        chk("t5_en", {bram_en, bram_we}, 2'b00);
        chk("t5_addr", bram_addr, 0);
        chk("t5_wdata", bram_wdata, 0);
        chk("t5_owner", owner, 0);
        step();
        chk("t5_rv_b", {b_rvalid, a_rvalid}, 2'b00);
        step();
        chk("t5_rv_c", {b_rvalid, a_rvalid}, 2'b00);

`ifdef ARB_HOST_PRIORITY_EN
        // ---- fixed priority: A always wins while requesting
        a_req = 1; a_lock = 0; a_we = 1; a_addr = 14'h0070;
        b_req = 1; b_lock = 0; b_we = 1; b_addr = 14'h0071;
        step();
        chk("t6_first_a", a_grant, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t6_b_starved", b_grant, 0);
            step();
        end
        a_req = 0;
        step();
        chk("t6_b_next", b_grant, 1);
        b_req = 0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
